// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// States are one-hot encoded so an illegal state is a simple onehot check.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int FRAME_W    = DEF_DATA_W + 2;

  // Command field, rx_data[9:8]
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    CHK_CMD   = 5'b00010,
    WRITE     = 5'b00100,
    READ_ADD  = 5'b01000,
    READ_DATA = 5'b10000
  } state_e;

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Bus between the SPI slave front end and its surroundings (SPI pins + RAM side).
//
// Handshake semantics:
//   rx_valid: single-cycle strobe from the slave; rx_data is valid only in that
//             cycle. There is no back-pressure, the RAM must accept it.
//   tx_valid: level from the RAM; tx_data is valid while it is high, and the RAM
//             holds it until it sees the next rx_valid. The slave consumes it at
//             most once per read-data frame.
interface spi_slave_fsm_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [DATA_W+1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// MISO serializer: loads one RAM word and shifts it out MSB first, one bit per
// edge, then drives 0. load_done blocks a second load while tx_valid stays high.
module spi_tx_serializer
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_en,
  input  logic [DATA_W-1:0] data,
  output logic              miso,
  output logic              load_done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-2:0] shreg;
  logic [CW-1:0]     bits_left;

  // Load on the first qualified edge, then shift out remaining bits; clear aborts.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      miso      <= 1'b0;
      shreg     <= '0;
      bits_left <= '0;
      load_done <= 1'b0;
    end else if (load_en && !load_done) begin
      miso      <= data[DATA_W-1];
      shreg     <= data[DATA_W-2:0];
      bits_left <= CW'(DATA_W - 1);
      load_done <= 1'b1;
    end else if (bits_left != '0) begin
      miso      <= shreg[DATA_W-2];
      shreg     <= shreg << 1;
      bits_left <= bits_left - 1'b1;
    end else begin
      miso      <= 1'b0;
    end
  end

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave front end (mode 0, clk is the SPI clock). Deserializes MOSI frames
// into command words for the RAM and serializes read-data replies on MISO.
// Optional macro SPI_SLAVE_SVA_EN compiles in concurrent assertions and covers.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_fsm_if.slave  bus,
  output state_e          state,
  output logic            rd_addr_seen
);

  localparam int FW    = DATA_W + 2;
  localparam int CNT_W = $clog2(FW);

  logic [FW-1:0]    rx_data;
  logic             rx_valid;
  logic [CNT_W-1:0] cnt;
  logic             frame_done;
  logic             load_en;
  logic             ser_clear;
  logic             miso;
  logic             load_done;

  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.MISO     = miso;

  // The reply is taken only after the rx_valid cycle of a completed read-data frame.
  assign load_en   = (state == READ_DATA) && frame_done && !rx_valid && bus.tx_valid;
  assign ser_clear = bus.SS_n || (state != READ_DATA);

  // Frame FSM, deserializer and rd_addr_seen tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      cnt          <= '0;
      frame_done   <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (bus.SS_n && (state != IDLE)) begin
        // Abort: a partial frame is dropped, rd_addr_seen is kept.
        state      <= IDLE;
        cnt        <= '0;
        frame_done <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt        <= '0;
            frame_done <= 1'b0;
            if (!bus.SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            rx_data    <= {bus.MOSI, {(FW-1){1'b0}}};
            cnt        <= '0;
            frame_done <= 1'b0;
            if (!bus.MOSI)        state <= WRITE;
            else if (rd_addr_seen) state <= READ_DATA;
            else                  state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              rx_data[FW-2:0] <= {rx_data[FW-3:0], bus.MOSI};
              if (cnt == CNT_W'(FW - 2)) begin
                frame_done <= 1'b1;
                rx_valid   <= 1'b1;
                cnt        <= '0;
                if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                if (state == READ_DATA) rd_addr_seen <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ser_clear),
    .load_en   (load_en),
    .data      (bus.tx_data),
    .miso      (miso),
    .load_done (load_done)
  );

`ifdef SPI_SLAVE_SVA_EN
  property p_rv_single;
    @(posedge clk) disable iff (!rst_n) rx_valid |=> !rx_valid;
  endproperty
  property p_rv_source;
    @(posedge clk) disable iff (!rst_n)
      rx_valid |-> (state inside {WRITE, READ_ADD, READ_DATA});
  endproperty
  property p_miso_quiet;
    @(posedge clk) disable iff (!rst_n) (state != READ_DATA) |-> !miso;
  endproperty
  property p_state_onehot;
    @(posedge clk) disable iff (!rst_n) $onehot(state);
  endproperty

  a_rv_single:    assert property (p_rv_single);
  a_rv_source:    assert property (p_rv_source);
  a_miso_quiet:   assert property (p_miso_quiet);
  a_state_onehot: assert property (p_state_onehot);

  c_rv_single:    cover property (p_rv_single);
  c_rv_source:    cover property (p_rv_source);
  c_miso_quiet:   cover property (p_miso_quiet);
  c_state_onehot: cover property (p_state_onehot);
`else
  // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Self-checking bench for spi_slave_fsm: table of frames plus hand-written
// abort sequences; rx_data words go through an expected queue.
module tb_spi_slave_fsm;
  import spi_pkg::*;

  localparam int DATA_W = 8;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;
  logic   dbg_seen;

  spi_slave_fsm_if #(.DATA_W(DATA_W)) bus ();

  spi_slave_fsm #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .state        (dbg_state),
    .rd_addr_seen (dbg_seen)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_W+1:0] exp_q[$];
  logic prev_rv = 1'b0;

  typedef struct {
    logic [9:0] word;
    state_e     exp_st;
    logic       exp_seen;
    logic       reply;
    logic [7:0] reply_data;
  } vec_t;

  vec_t vecs[9];
  logic m_seen;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every rx_valid strobe pops one expected word.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.rx_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_valid_unexpected: got strobe with rx_data %0h expected none", bus.rx_data);
        end else begin
          check("rx_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
        end
        check("rx_valid_pulse", 32'(prev_rv), 32'd0);
      end
      prev_rv = bus.rx_valid;
    end else begin
      prev_rv = 1'b0;
    end
  end

  // One frame starting from IDLE with SS_n high; optional RAM reply and MISO abort.
  task automatic run_frame(input logic [9:0] word, input state_e exp_st, input logic exp_seen,
                           input logic reply, input logic [7:0] reply_data, input int abort_after);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'($urandom_range(0, 1));
    tick(); // edge 0
    check("enter_chk_cmd", 32'(dbg_state), 32'(CHK_CMD));
    bus.MOSI = word[9];
    tick(); // edge 1
    check("cmd_state", 32'(dbg_state), 32'(exp_st));
    for (int i = 8; i >= 0; i--) begin
      bus.MOSI = word[i];
      if (i == 0) exp_q.push_back(word);
      tick(); // edges 2..10
    end
    check("rx_valid_edge10", 32'(bus.rx_valid), 32'd1);
    check("rd_addr_seen", 32'(dbg_seen), 32'(exp_seen));
    bus.MOSI = 1'($urandom_range(0, 1));
    tick(); // edge 11: RAM drops any old tx_valid, then replies
    bus.tx_valid = reply;
    bus.tx_data  = reply_data;
    check("rx_valid_off", 32'(bus.rx_valid), 32'd0);
    check("miso_before_reply", 32'(bus.MISO), 32'd0);
    if (reply) begin
      for (int k = 0; k < 8; k++) begin
        bus.MOSI = 1'($urandom_range(0, 1));
        tick(); // edges 12..19
        check("miso_bit", 32'(bus.MISO), 32'(reply_data[7-k]));
        if (abort_after != 0 && k + 1 == abort_after) begin
          bus.SS_n = 1'b1;
          tick();
          check("miso_abort", 32'(bus.MISO), 32'd0);
          check("abort_idle", 32'(dbg_state), 32'(IDLE));
          return;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      bus.MOSI = 1'($urandom_range(0, 1));
      tick();
      check("miso_quiet", 32'(bus.MISO), 32'd0);
    end
    bus.SS_n = 1'b1;
    tick();
    check("frame_end_idle", 32'(dbg_state), 32'(IDLE));
    check("frame_end_miso", 32'(bus.MISO), 32'd0);
  endtask

  initial begin
    vecs[0] = '{{CMD_WR_ADDR, 8'h3C}, WRITE,     1'b0, 1'b0, 8'h00};
    vecs[1] = '{{CMD_WR_DATA, 8'hA5}, WRITE,     1'b0, 1'b0, 8'h00};
    vecs[2] = '{{CMD_RD_ADDR, 8'h3C}, READ_ADD,  1'b1, 1'b0, 8'h00};
    vecs[3] = '{{CMD_RD_DATA, 8'hFF}, READ_DATA, 1'b0, 1'b1, 8'hA5};
    vecs[4] = '{{CMD_RD_ADDR, 8'hAA}, READ_ADD,  1'b1, 1'b0, 8'h00};
    vecs[5] = '{{CMD_RD_DATA, 8'h00}, READ_DATA, 1'b0, 1'b1, 8'h3C};
    vecs[6] = '{{CMD_RD_DATA, 8'h55}, READ_ADD,  1'b1, 1'b0, 8'h00};
    vecs[7] = '{{CMD_WR_DATA, 8'h00}, WRITE,     1'b1, 1'b0, 8'h00};
    vecs[8] = '{{CMD_RD_ADDR, 8'hC3}, READ_DATA, 1'b0, 1'b1, 8'h81};

    // Reset with MOSI toggling
    rst_n        = 1'b0;
    bus.SS_n     = 1'b0;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    for (int c = 0; c < 2; c++) begin
      bus.MOSI = ~bus.MOSI;
      tick();
      check("rst_miso", 32'(bus.MISO), 32'd0);
      check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      check("rst_seen", 32'(dbg_seen), 32'd0);
    end
    rst_n    = 1'b1;
    bus.SS_n = 1'b1;
    tick();
    check("post_rst_idle", 32'(dbg_state), 32'(IDLE));

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].word, vecs[v].exp_st, vecs[v].exp_seen,
                vecs[v].reply, vecs[v].reply_data, 0);
    end
    m_seen = 1'b0;

    // Partial write frame: 5 bits then SS_n high, no strobe
    bus.SS_n = 1'b0;
    tick(); // edge 0
    bus.MOSI = 1'b0;
    tick(); // bit 9
    for (int i = 0; i < 4; i++) begin
      bus.MOSI = 1'b1;
      tick();
    end
    bus.SS_n = 1'b1;
    tick();
    check("partial_idle", 32'(dbg_state), 32'(IDLE));
    check("partial_no_rv", 32'(bus.rx_valid), 32'd0);
    tick();
    check("partial_no_rv2", 32'(bus.rx_valid), 32'd0);
    run_frame({CMD_WR_ADDR, 8'h11}, WRITE, 1'b0, 1'b0, 8'h00, 0);

    // MISO aborted after 3 bits, then read-address goes to READ_ADD
    run_frame({CMD_RD_ADDR, 8'h3C}, READ_ADD, 1'b1, 1'b0, 8'h00, 0);
    run_frame({CMD_RD_DATA, 8'h3C}, READ_DATA, 1'b0, 1'b1, 8'hC6, 3);
    run_frame({CMD_RD_ADDR, 8'h10}, READ_ADD, 1'b1, 1'b0, 8'h00, 0);
    m_seen = 1'b1;

    // Random frames against the command model
    for (int r = 0; r < 6; r++) begin
      logic [9:0] w;
      state_e     st;
      logic [7:0] d;
      w = 10'($urandom_range(0, 1023));
      d = 8'($urandom_range(0, 255));
      if (!w[9])      st = WRITE;
      else if (m_seen) st = READ_DATA;
      else            st = READ_ADD;
      if (st == READ_ADD)  m_seen = 1'b1;
      if (st == READ_DATA) m_seen = 1'b0;
      run_frame(w, st, m_seen, (st == READ_DATA), d, 0);
    end

    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
# spi_slave_fsm

SPI slave front end for the SPI-to-RAM path. Deserializes MOSI frames into 10-bit command words on `rx_data`/`rx_valid` for the downstream single-port RAM. For read-data commands it captures the RAM's `tx_data`/`tx_valid` reply and serializes it MSB-first on MISO. Mode 0; `clk` is the SPI clock.

## Interface
- `DATA_W`, default 8: RAM word and address width. The frame is `DATA_W+2` bits.
- `clk` input, 1 bit: SPI clock. MOSI is sampled and MISO is driven on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `SS_n` input, 1 bit: slave select, active-low; frame delimiter.
- `MOSI` input, 1 bit: serial data in, MSB first.
- `MISO` output, 1 bit: serial data out, MSB first.
- `rx_data` output, `DATA_W+2` bits: assembled command word to the RAM. `[9:8]` is the command (00 write-address, 01 write-data, 10 read-address, 11 read-data); `[7:0]` is the payload.
- `rx_valid` output, 1 bit: one-cycle strobe, `rx_data` valid.
- `tx_data` input, `DATA_W` bits: RAM read data.
- `tx_valid` input, 1 bit: RAM read data valid. Level signal that the RAM holds until its next `rx_valid`.

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- Internal flag `rd_addr_seen` is held across frames.
- IDLE:
  - `SS_n`=0 → CHK_CMD.
- CHK_CMD:
  - The sampled MOSI becomes `rx_data[9]`.
  - MOSI=0 → WRITE.
  - MOSI=1 with `rd_addr_seen`=0 → READ_ADD.
  - MOSI=1 with `rd_addr_seen`=1 → READ_DATA.
- WRITE / READ_ADD / READ_DATA:
  - Shift in the remaining 9 bits (`rx_data[8:0]`), MSB first, using a 4-bit counter.
  - On the 9th bit edge, `rx_data` holds the full word and `rx_valid` is 1 during the following cycle only.
  - No further bits are captured afterwards.
  - `rx_data[8]` is forwarded unchecked.
- Flag updates:
  - Completion of a READ_ADD frame sets `rd_addr_seen`.
  - Completion of a READ_DATA frame clears it.
- READ_DATA reply:
  - After `rx_valid`, the FSM waits for `tx_valid`=1.
  - On the first edge with `tx_valid`=1 it loads the shift register and drives MISO=`tx_data[7]`.
  - Bits 6..0 follow on the next 7 edges, one per edge.
  - MISO then returns to 0.
  - A `load_done` flag prevents a reload while `tx_valid` stays high.
  - `tx_valid` is ignored in all other states.
- `SS_n`=1 in any non-IDLE state → IDLE on that edge.
  - Counters, shift registers and `load_done` clear; MISO=0.
  - A partial frame never produces `rx_valid`.
  - `rd_addr_seen` is preserved, except that it updates normally if the frame completed.
- Excess MOSI bits after frame completion are ignored until `SS_n` deasserts.

## Timing
- Reset: MISO=0, `rx_valid`=0, `rx_data`=0, state=IDLE, `rd_addr_seen`=0, counters=0.
- Edge 0 (`SS_n` low sampled) enters CHK_CMD.
- Edge 1 samples bit 9.
- Edges 2–10 sample bits 8..0.
- `rx_valid` is high in the cycle after edge 10.
- The RAM's `tx_valid` is high from the next edge.
- MISO bit 7 is driven on the edge that samples `tx_valid`, i.e. 2 edges after the `rx_valid` cycle starts.
- The read-data frame therefore needs `SS_n` low for at least 21 edges.
- Back-to-back frames need `SS_n` high for at least 1 edge.

## Configuration
- `SPI_SLAVE_SVA_EN` defined: concurrent assertions compile in.
  - `rx_valid` is never high for 2 consecutive cycles.
  - `rx_valid` occurs only from WRITE, READ_ADD or READ_DATA.
  - MISO=0 outside READ_DATA.
  - The state is one-hot-legal.
  - Each checked property is also covered.
- Undefined: no assertion code; functionally identical.

## Structure
- Package `spi_pkg`:
  - `state_e` enum.
  - Command constants `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11.
  - `FRAME_W`.
- Sub-module `spi_tx_serializer`: load/shift MISO serializer with `load_done`. The FSM and deserializer stay in the top module.

## Test plan
- Reset held 2 cycles with MOSI toggling → all outputs 0, state IDLE.
- Write-address frame 00_0x3C, then write-data frame 01_0xA5 → `rx_data`=0x03C, then 0x1A5, each with a single-cycle `rx_valid` after edge 10.
- Read-address 10_0x3C, then read-data 11_xx with `tx_valid`/`tx_data`=0xA5 modelled one edge after `rx_valid`:
  - `rx_data`=0x23C, then 0x3xx.
  - MISO=1,0,1,0,0,1,0,1.
  - `rd_addr_seen` ends at 0.
- Two consecutive frames starting with bit 9=1 → the first takes READ_ADD and the second READ_DATA. A third frame with bit 9=1 takes READ_ADD again.
- `SS_n` raised after 5 bits of a write frame → no `rx_valid`. The next full frame 00_0x11 gives `rx_data`=0x011.
- `SS_n` raised mid-MISO (after 3 bits) → MISO=0 on the next edge. The following read-address frame goes to READ_ADD.
